// File: rtl/frame_fetch_unit_pkg.sv
// Shared constants for the frame fetch path: packed-trit encoding and trit width.
package frame_fetch_unit_pkg;

    localparam int unsigned TRIT_W = 2;

    localparam logic [TRIT_W-1:0] TRIT_ZERO    = 2'b00;
    localparam logic [TRIT_W-1:0] TRIT_POS     = 2'b01;
    localparam logic [TRIT_W-1:0] TRIT_NEG     = 2'b10;
    localparam logic [TRIT_W-1:0] TRIT_INVALID = 2'b11;

endpackage

// File: rtl/frame_fetch_unit_fifo.sv
// fetch_fifo: synchronous first-word-fall-through FIFO with an exported occupancy count.
module fetch_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);

    // Head is forced to zero while empty so the output is defined out of reset.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/frame_fetch_unit.sv
// Fetch stage between the frame controller and the lane array: credit-limited in-order reads into a FWFT buffer.
// Optional build macro FETCH_TRIT_CHECK_EN scrubs invalid (11) trits to 00 and raises a sticky trit_err.
module frame_fetch_unit
    import frame_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LANE_COUNT = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         engine_enable,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_ready,
    output logic                         bus_req,
    output logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic                         bus_gnt,
    input  logic                         bus_rvalid,
    input  logic [DATA_WIDTH-1:0]        bus_rdata,
    output logic                         lane_valid,
    input  logic                         lane_ready,
    output logic [TRIT_W*LANE_COUNT-1:0] lane_trits,
    output logic                         busy,
    output logic                         trit_err
);

    localparam int unsigned WORD_W = TRIT_W * LANE_COUNT;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;

    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  in_flight;
    logic              credit;
    logic              grant;
    logic              rsp_valid;
    logic              pop;
    logic [WORD_W-1:0] push_word;

    // Credit covers both buffered words and reads still on the bus.
    assign in_flight = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign credit    = in_flight < SUM_W'(FIFO_DEPTH);

    assign bus_req   = engine_enable & credit & ~reset;
    assign bus_addr  = mem_addr;
    assign grant     = bus_req & bus_gnt;
    assign mem_ready = grant;

    // Responses with nothing outstanding are stray (e.g. after reset) and dropped.
    assign rsp_valid = bus_rvalid & (outstanding != '0);

    assign lane_valid = (fifo_count != '0);
    assign pop        = lane_valid & lane_ready;
    assign busy       = engine_enable | (outstanding != '0) | (fifo_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp_valid);
        end
    end

`ifdef FETCH_TRIT_CHECK_EN
    logic word_bad;

    always_comb begin
        push_word = bus_rdata[WORD_W-1:0];
        word_bad  = 1'b0;
        for (int i = 0; i < int'(LANE_COUNT); i++) begin
            if (bus_rdata[i*TRIT_W +: TRIT_W] == TRIT_INVALID) begin
                push_word[i*TRIT_W +: TRIT_W] = TRIT_ZERO;
                word_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trit_err <= 1'b0;
        end else if (rsp_valid & word_bad) begin
            trit_err <= 1'b1;
        end
    end
`else
    assign push_word = bus_rdata[WORD_W-1:0];
    assign trit_err  = 1'b0;
`endif

    // Bus data above the packed-trit word carries nothing for the lanes.
    if (DATA_WIDTH > WORD_W) begin : g_rdata_hi
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^bus_rdata[DATA_WIDTH-1:WORD_W];
    end

    fetch_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_valid),
        .push_data (push_word),
        .pop       (pop),
        .head      (lane_trits),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_frame_fetch_unit.sv
// Directed self-checking bench for frame_fetch_unit; each scenario task checks its own expected values.
module tb_frame_fetch_unit;

    logic        clk;
    logic        reset;
    logic        engine_enable;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        lane_valid;
    logic        lane_ready;
    logic [29:0] lane_trits;
    logic        busy;
    logic        trit_err;

    int vectors;
    int miscompares;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    int unsigned cyc_no;
    int unsigned lat;
    bit          auto_bus;

    frame_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .engine_enable (engine_enable),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .lane_valid    (lane_valid),
        .lane_ready    (lane_ready),
        .lane_trits    (lane_trits),
        .busy          (busy),
        .trit_err      (trit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected lane word for a bench address: lane k (k = addr[5:2]) is +1, lane 14 is -1.
    function automatic logic [29:0] exp_of(logic [31:0] a);
        logic [29:0] w;
        w = 30'h1;
        return 30'h2000_0000 | (w << (2 * a[5:2]));
    endfunction

    // Bus word carries junk in the ignored upper bits.
    function automatic logic [31:0] word_of(logic [31:0] a);
        return {2'b11, exp_of(a)};
    endfunction

    // Advance one clock; the optional bus model returns data `lat` cycles after each grant.
    task automatic adv();
        if (auto_bus && mem_ready)
            rsp_q.push_back('{due: cyc_no + lat, data: word_of(mem_addr)});
        @(posedge clk);
        #1;
        cyc_no++;
        if (auto_bus) begin
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_no) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else begin
                bus_rvalid = 1'b0;
                bus_rdata  = '0;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        rsp_q.delete();
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1; engine_enable = 1'b0; settle();
        vectors++; if (bus_req !== 1'b0)    begin miscompares++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        vectors++; if (mem_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
        vectors++; if (lane_valid !== 1'b0) begin miscompares++; $display("FAIL reset_lane_valid got %b want 0", lane_valid); end
        vectors++; if (lane_trits !== 30'h0) begin miscompares++; $display("FAIL reset_lane_trits got %h want 0", lane_trits); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (trit_err !== 1'b0)   begin miscompares++; $display("FAIL reset_trit_err got %b want 0", trit_err); end
        engine_enable = 1'b1; bus_gnt = 1'b1; settle();
        vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL reset_busy_en got %b want 1", busy); end
        vectors++; if (mem_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_mem_ready_en got %b want 0", mem_ready); end
        engine_enable = 1'b0; bus_gnt = 1'b0;
        adv();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_single_beat();
        auto_bus = 1'b0; lane_ready = 1'b0;
        engine_enable = 1'b1; mem_addr = 32'h1000; bus_gnt = 1'b1; settle();
        vectors++; if (mem_ready !== 1'b1)     begin miscompares++; $display("FAIL single_mem_ready got %b want 1", mem_ready); end
        vectors++; if (bus_addr !== 32'h1000)  begin miscompares++; $display("FAIL single_bus_addr got %h want 1000", bus_addr); end
        adv();
        engine_enable = 1'b0; settle();
        vectors++; if (mem_ready !== 1'b0)     begin miscompares++; $display("FAIL single_mem_ready_pulse got %b want 0", mem_ready); end
        adv();
        bus_rvalid = 1'b1; bus_rdata = 32'h1555_5555; settle();
        vectors++; if (lane_valid !== 1'b0)    begin miscompares++; $display("FAIL single_early_valid got %b want 0", lane_valid); end
        adv();
        bus_rvalid = 1'b0; bus_rdata = '0; settle();
        vectors++; if (lane_valid !== 1'b1)    begin miscompares++; $display("FAIL single_lane_valid got %b want 1", lane_valid); end
        vectors++; if (lane_trits !== 30'h1555_5555) begin miscompares++; $display("FAIL single_lane_trits got %h want 15555555", lane_trits); end
        lane_ready = 1'b1;
        adv();
        lane_ready = 1'b0; settle();
        vectors++; if (lane_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_drain got valid=%b busy=%b want 0 0", lane_valid, busy); end
    endtask

    task automatic test_backpressure();
        int idx;
        int grants;
        bit acc;
        idx = 0; grants = 0;
        auto_bus = 1'b1; lat = 1; lane_ready = 1'b0; bus_gnt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            engine_enable = (idx < 6);
            mem_addr = 32'h2000 + 32'(4 * idx);
            settle();
            acc = mem_ready;
            if (acc) grants++;
            adv();
            if (acc) idx++;
        end
        engine_enable = 1'b1; mem_addr = 32'h2000 + 32'(4 * idx); settle();
        vectors++; if (grants !== 4)          begin miscompares++; $display("FAIL bp_grants got %0d want 4", grants); end
        vectors++; if (bus_req !== 1'b0 || mem_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stalled got req=%b rdy=%b want 0 0", bus_req, mem_ready); end
        lane_ready = 1'b1; settle();
        vectors++; if (mem_ready !== 1'b0)    begin miscompares++; $display("FAIL bp_pop_cycle_ready got %b want 0", mem_ready); end
        vectors++; if (lane_trits !== exp_of(32'h2000)) begin miscompares++; $display("FAIL bp_word0 got %h want %h", lane_trits, exp_of(32'h2000)); end
        adv();
        lane_ready = 1'b0; settle();
        vectors++; if (mem_ready !== 1'b1 || bus_addr !== 32'h2010) begin miscompares++; $display("FAIL bp_reaccept got rdy=%b addr=%h want 1 2010", mem_ready, bus_addr); end
        adv();
        idx++;
        mem_addr = 32'h2000 + 32'(4 * idx); settle();
        vectors++; if (mem_ready !== 1'b0)    begin miscompares++; $display("FAIL bp_single_extra got %b want 0", mem_ready); end
        engine_enable = 1'b0; lane_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            vectors++;
            if (lane_valid !== 1'b1 || lane_trits !== exp_of(32'h2000 + 32'(4 * k))) begin
                miscompares++;
                $display("FAIL bp_order_%0d got valid=%b %h want 1 %h", k, lane_valid, lane_trits, exp_of(32'h2000 + 32'(4 * k)));
            end
            adv();
        end
        lane_ready = 1'b0; settle();
        vectors++; if (lane_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_empty got valid=%b busy=%b want 0 0", lane_valid, busy); end
    endtask

    task automatic test_grant_stall();
        auto_bus = 1'b1; lat = 1; lane_ready = 1'b0;
        engine_enable = 1'b1; mem_addr = 32'h3000; bus_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            vectors++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h3000 || mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cycle_%0d got req=%b addr=%h rdy=%b want 1 3000 0", c, bus_req, bus_addr, mem_ready);
            end
            adv();
        end
        bus_gnt = 1'b1; settle();
        vectors++; if (mem_ready !== 1'b1)  begin miscompares++; $display("FAIL stall_accept got %b want 1", mem_ready); end
        adv();
        engine_enable = 1'b0; settle();
        vectors++; if (lane_valid !== 1'b0) begin miscompares++; $display("FAIL stall_rvalid_cycle got %b want 0", lane_valid); end
        adv();
        lane_ready = 1'b1; settle();
        vectors++; if (lane_valid !== 1'b1 || lane_trits !== exp_of(32'h3000)) begin miscompares++; $display("FAIL stall_word got valid=%b %h want 1 %h", lane_valid, lane_trits, exp_of(32'h3000)); end
        adv();
        lane_ready = 1'b0; settle();
        vectors++; if (lane_valid !== 1'b0) begin miscompares++; $display("FAIL stall_popped got %b want 0", lane_valid); end
    endtask

    task automatic test_full_push_pop();
        int idx;
        int popped;
        bit acc;
        idx = 0; popped = 0;
        auto_bus = 1'b1; lat = 1; bus_gnt = 1'b1;
        for (int c = 0; c < 40 && popped < 8; c++) begin
            engine_enable = (idx < 8);
            mem_addr = 32'h4000 + 32'(4 * idx);
            lane_ready = (c >= 4);
            settle();
            if (c == 4 || c == 5) begin
                vectors++;
                if (dut.fifo_count !== 3'd3) begin miscompares++; $display("FAIL full_count_c%0d got %0d want 3", c, dut.fifo_count); end
            end
            if (lane_valid && lane_ready) begin
                vectors++;
                if (lane_trits !== exp_of(32'h4000 + 32'(4 * popped))) begin
                    miscompares++;
                    $display("FAIL full_order_%0d got %h want %h", popped, lane_trits, exp_of(32'h4000 + 32'(4 * popped)));
                end
                popped++;
            end
            acc = mem_ready;
            adv();
            if (acc) idx++;
        end
        engine_enable = 1'b0; lane_ready = 1'b0; settle();
        vectors++; if (popped !== 8) begin miscompares++; $display("FAIL full_popped got %0d want 8", popped); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        auto_bus = 1'b0; lane_ready = 1'b0;
        engine_enable = 1'b1; bus_gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mem_addr = 32'h5000 + 32'(4 * c);
            settle();
            adv();
        end
        engine_enable = 1'b0; settle();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b want 1", busy); end
        reset = 1'b1; settle();
        vectors++;
        if (bus_req !== 1'b0 || mem_ready !== 1'b0 || lane_valid !== 1'b0 || lane_trits !== 30'h0 || busy !== 1'b0 || trit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got req=%b rdy=%b v=%b t=%h busy=%b err=%b want all 0", bus_req, mem_ready, lane_valid, lane_trits, busy, trit_err);
        end
        adv();
        reset = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0005;
        adv();
        adv();
        bus_rvalid = 1'b0; bus_rdata = '0; settle();
        vectors++; if (lane_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_stray_rvalid got valid=%b busy=%b want 0 0", lane_valid, busy); end
    endtask

    task automatic test_trit_check();
        logic [29:0] exp_word;
        logic        exp_err;
`ifdef FETCH_TRIT_CHECK_EN
        exp_word = 30'h0000_0005;
        exp_err  = 1'b1;
`else
        exp_word = 30'h0000_00C5;
        exp_err  = 1'b0;
`endif
        auto_bus = 1'b0; lane_ready = 1'b0;
        engine_enable = 1'b1; mem_addr = 32'h6000; bus_gnt = 1'b1; settle();
        adv();
        engine_enable = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_00C5;
        adv();
        bus_rvalid = 1'b0; bus_rdata = '0; settle();
        vectors++; if (lane_valid !== 1'b1 || lane_trits !== exp_word) begin miscompares++; $display("FAIL trit_word got valid=%b %h want 1 %h", lane_valid, lane_trits, exp_word); end
        vectors++; if (trit_err !== exp_err) begin miscompares++; $display("FAIL trit_err_set got %b want %b", trit_err, exp_err); end
        lane_ready = 1'b1;
        adv();
        lane_ready = 1'b0; settle();
        vectors++; if (trit_err !== exp_err || lane_valid !== 1'b0) begin miscompares++; $display("FAIL trit_err_sticky got err=%b valid=%b want %b 0", trit_err, lane_valid, exp_err); end
        do_reset();
        vectors++; if (trit_err !== 1'b0) begin miscompares++; $display("FAIL trit_err_cleared got %b want 0", trit_err); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        cyc_no = 0; lat = 1; auto_bus = 1'b0;
        reset = 1'b1; engine_enable = 1'b0; mem_addr = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; lane_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        do_reset();
        test_grant_stall();
        do_reset();
        test_full_push_pop();
        do_reset();
        test_reset_mid_frame();
        test_trit_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
